// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
// Bit-serial subtractor controller. Computes a_in - b_in - borrow_in over W bits
// by driving one shared external 1-bit full-subtractor cell, LSB first, one bit
// per clock. The cell's diff output is collected into an accumulator and its
// borrow output is fed back as the next bit's borrow-in.

module serial_sub_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         borrow_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff_out,
    output logic         borrow_out,
    output logic         fs_a,
    output logic         fs_b,
    output logic         fs_bin,
    input  logic         fs_diff,
    input  logic         fs_borr
);

    // One extra counter bit keeps the width non-zero when W is 1.
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   acc;
    logic           brw;
    logic [CW-1:0]  cnt;

    logic           accept;
    logic           last_bit;
    logic [W-1:0]   acc_nxt;

    // The accumulator fills from the top, so after W shifts bit i holds the
    // diff of the i-th processed bit. Written with shifts so W=1 needs no
    // special-case slicing.
    assign acc_nxt = (acc >> 1) | (W'(fs_diff) << (W - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus all state-decoded outputs, including the cell drive.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        fs_a      = 1'b0;
        fs_b      = 1'b0;
        fs_bin    = 1'b0;
        accept    = 1'b0;
        last_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                fs_a   = a_sh[0];
                fs_b   = b_sh[0];
                fs_bin = brw;
                if (cnt == LAST_BIT) begin
                    last_bit  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand shifters, running borrow and bit counter: load on accept, step each RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            a_sh <= a_in;
            b_sh <= b_in;
            acc  <= '0;
            brw  <= borrow_in;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            acc  <= acc_nxt;
            brw  <= fs_borr;
            cnt  <= cnt + CW'(1);
        end
    end

    // Result registers: captured on the last bit and held until the next completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_out   <= '0;
            borrow_out <= 1'b0;
        end else if (last_bit) begin
            diff_out   <= acc_nxt;
            borrow_out <= fs_borr;
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl
// Drives a W=4 and a W=1 instance of serial_sub_ctrl, each wired to its own
// full-subtractor cell, and checks results against plain arithmetic.

module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       start4, bin4, busy4, done4, borr4;
    logic [3:0] a4, b4, diff4;
    logic       fa4, fb4, fbin4, fd4, fbr4;

    logic       start1, bin1, busy1, done1, borr1;
    logic [0:0] a1, b1, diff1;
    logic       fa1, fb1, fbin1, fd1, fbr1;

    int         total = 0;
    int         bad = 0;
    logic [3:0] lastDiff;
    logic       lastBorrow;

    // Shared full-subtractor cells.
    assign fd4  = fa4 ^ fb4 ^ fbin4;
    assign fbr4 = (~fa4 & fb4) | (~(fa4 ^ fb4) & fbin4);
    assign fd1  = fa1 ^ fb1 ^ fbin1;
    assign fbr1 = (~fa1 & fb1) | (~(fa1 ^ fb1) & fbin1);

    serial_sub_ctrl #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .a_in(a4), .b_in(b4), .borrow_in(bin4),
        .busy(busy4), .done(done4), .diff_out(diff4), .borrow_out(borr4),
        .fs_a(fa4), .fs_b(fb4), .fs_bin(fbin4),
        .fs_diff(fd4), .fs_borr(fbr4)
    );

    serial_sub_ctrl #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a_in(a1), .b_in(b1), .borrow_in(bin1),
        .busy(busy1), .done(done1), .diff_out(diff1), .borrow_out(borr1),
        .fs_a(fa1), .fs_b(fb1), .fs_bin(fbin1),
        .fs_diff(fd1), .fs_borr(fbr1)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {borrow, diff} for a w-bit unsigned subtraction.
    function automatic logic [4:0] refSub(input int w, input int a, input int b, input int bin);
        int d;
        int mask;
        logic brw;
        d    = a - b - bin;
        mask = (1 << w) - 1;
        brw  = (a < b + bin);
        return {brw, 4'(d & mask)};
    endfunction

    // One complete operation on the selected instance (which = 1 or 4).
    task automatic applyStimulus(input int which, input logic [3:0] a, input logic [3:0] b, input logic bin);
        int         w;
        int         lat;
        int         busyCnt;
        logic [4:0] exp;
        logic       curDone;
        logic       curBusy;
        logic [3:0] gd;
        logic       gb;
        w = (which == 1) ? 1 : 4;
        if (which == 1) begin
            a = {3'b000, a[0]};
            b = {3'b000, b[0]};
        end
        exp = refSub(w, int'(a), int'(b), int'(bin));
        @(negedge clk);
        if (which == 1) begin
            a1 = a[0]; b1 = b[0]; bin1 = bin; start1 = 1'b1;
        end else begin
            a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
        a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
        lat = 1;
        busyCnt = 0;
        curDone = (which == 1) ? done1 : done4;
        curBusy = (which == 1) ? busy1 : busy4;
        while (!curDone && lat < 20) begin
            if (curBusy) busyCnt++;
            @(negedge clk);
            lat++;
            curDone = (which == 1) ? done1 : done4;
            curBusy = (which == 1) ? busy1 : busy4;
        end
        gd = (which == 1) ? {3'b000, diff1} : diff4;
        gb = (which == 1) ? borr1 : borr4;
        checkOutput($sformatf("w%0d_latency", w), lat, w + 1);
        checkOutput($sformatf("w%0d_busyCycles", w), busyCnt, w);
        checkOutput($sformatf("w%0d_diff a=%0d b=%0d bin=%0d", w, a, b, bin), gd, exp[3:0]);
        checkOutput($sformatf("w%0d_borrow a=%0d b=%0d bin=%0d", w, a, b, bin), gb, exp[4]);
        checkOutput($sformatf("w%0d_busyAtDone", w), curBusy, 0);
        if (which == 1) checkOutput("w1_fsAtDone", {fa1, fb1, fbin1}, 0);
        else            checkOutput("w4_fsAtDone", {fa4, fb4, fbin4}, 0);
        lastDiff   = gd;
        lastBorrow = gb;
    endtask

    initial begin
        logic [8:0] ops [24];
        logic [4:0] exp;
        logic       expDone;

        rst = 1'b1;
        start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        start1 = 0; a1 = 0; b1 = 0; bin1 = 0;

        // Reset state.
        @(negedge clk);
        checkOutput("rst_busy", busy4, 0);
        checkOutput("rst_done", done4, 0);
        checkOutput("rst_diff", diff4, 0);
        checkOutput("rst_borrow", borr4, 0);
        checkOutput("rst_fs", {fa4, fb4, fbin4}, 0);
        rst = 1'b0;

        // Directed cases.
        applyStimulus(4, 4'd9, 4'd3, 1'b0);
        checkOutput("t1_diff", lastDiff, 4'h6);
        checkOutput("t1_borrow", lastBorrow, 0);
        applyStimulus(4, 4'd3, 4'd9, 1'b0);
        checkOutput("t2_diff", lastDiff, 4'hA);
        checkOutput("t2_borrow", lastBorrow, 1);

        // Reset during RUN after two bits.
        @(negedge clk);
        a4 = 4'd14; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_busy", busy4, 0);
        checkOutput("t5_done", done4, 0);
        checkOutput("t5_diff", diff4, 0);
        checkOutput("t5_borrow", borr4, 0);
        checkOutput("t5_fs", {fa4, fb4, fbin4}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("t5_noDone", done4, 0);
            checkOutput("t5_noBusy", busy4, 0);
        end
        applyStimulus(4, 4'd12, 4'd7, 1'b0);
        checkOutput("t5_nextDiff", lastDiff, 4'h5);
        checkOutput("t5_nextBorrow", lastBorrow, 0);

        applyStimulus(4, 4'd5, 4'd5, 1'b1);
        checkOutput("t3_diff", lastDiff, 4'hF);
        checkOutput("t3_borrow", lastBorrow, 1);
        applyStimulus(4, 4'd0, 4'd0, 1'b0);
        checkOutput("t3z_diff", lastDiff, 4'h0);
        checkOutput("t3z_borrow", lastBorrow, 0);

        // start held high with operands changing every cycle.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i > 0) begin
                expDone = (i % 6 == 5);
                checkOutput($sformatf("t4_done i=%0d", i), done4, expDone);
                if (expDone) begin
                    exp = refSub(4, int'(ops[i-5][3:0]), int'(ops[i-5][7:4]), int'(ops[i-5][8]));
                    checkOutput("t4_diff", diff4, exp[3:0]);
                    checkOutput("t4_borrow", borr4, exp[4]);
                end
            end
            ops[i] = 9'($urandom);
            a4 = ops[i][3:0];
            b4 = ops[i][7:4];
            bin4 = ops[i][8];
            start4 = 1'b1;
        end
        @(negedge clk);
        start4 = 1'b0;

        // Exhaustive W=4.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    applyStimulus(4, 4'(a), 4'(b), 1'(c));

        // W=1 truth table.
        for (int k = 0; k < 8; k++)
            applyStimulus(1, {3'b000, 1'(k >> 2)}, {3'b000, 1'(k >> 1)}, 1'(k));

        // Random mix on both instances.
        for (int k = 0; k < 40; k++)
            applyStimulus((k % 4 == 3) ? 1 : 4, 4'($urandom), 4'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
